arith_cmd_seq: RTL and testbench



---
 rtl/arith_pkg.sv | 27 ++
 rtl/arith_settle_cnt.sv | 40 ++++
 rtl/arith_cmd_seq.sv | 154 +++++++++++++++
 tb/tb_arith_cmd_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic command sequencer: op encodings,
// flag bit positions, FSM state type and the reserved-op decode helper.
// Combinational only; no latency; no backpressure.
package arith_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_CMP  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    localparam int FLAG_GT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 0;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic is_rsvd_op(input logic [1:0] op);
        return op == OP_RSVD;
    endfunction

endpackage

// File: rtl/arith_settle_cnt.sv
// Loadable down-counter timing how long ALU operands are held before capture.
// Latency: load/decrement take effect at the next edge; done is a decode of the count.
// Backpressure: none; decrement saturates at zero.
// Ports: clk, rst (sync, active-high), load/load_val, dec -> cnt, done (cnt == 0).
module arith_settle_cnt
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == '0);

endmodule

// File: rtl/arith_cmd_seq.sv
// Sequences one command at a time through an external combinational ALU.
// Latency: response valid SETTLE_CYCLES+1 cycles after the accepting edge.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready.
// Ports: clk/rst; cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op in; alu_a/alu_b/alu_ctrl
// out to the ALU, alu_result/alu_flag back; rsp_valid/rsp_ready/rsp_result/
// rsp_flag/rsp_err out; busy and rsp_count status.
module arith_cmd_seq
    import arith_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_ctrl,
    input  logic [3:0] alu_result,
    input  logic [2:0] alu_flag,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [2:0] rsp_flag,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] rsp_count
);

    // Counter is loaded with SETTLE_CYCLES-1 so that the SETTLE state spans
    // exactly SETTLE_CYCLES cycles, ending on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t     state_q,      state_d;
    logic [3:0] alu_a_q,      alu_a_d;
    logic [3:0] alu_b_q,      alu_b_d;
    logic [1:0] alu_ctrl_q,   alu_ctrl_d;
    logic       rsp_valid_q,  rsp_valid_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic [2:0] rsp_flag_q,   rsp_flag_d;
    logic       rsp_err_q,    rsp_err_d;
    logic       busy_q,       busy_d;
    logic [7:0] rsp_count_q,  rsp_count_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_val;

    arith_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        rsp_err_d    = rsp_err_q;
        busy_d       = busy_q;
        rsp_count_d  = rsp_count_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d    = cmd_a;
                    alu_b_d    = cmd_b;
                    alu_ctrl_d = cmd_op;
                    cnt_load   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_done) begin
                    // The registered op is used for the error flag: cmd_op
                    // itself may have moved on since acceptance.
                    rsp_result_d = alu_result;
                    rsp_flag_d   = alu_flag;
                    rsp_err_d    = is_rsvd_op(alu_ctrl_q);
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    rsp_count_d = rsp_count_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            rsp_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            rsp_count_q  <= rsp_count_d;
        end
    end

    // Gated by rst so the block never advertises readiness while in reset,
    // yet is ready in the very first cycle after reset is released.
    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign rsp_count  = rsp_count_q;

endmodule

// File: tb/tb_arith_cmd_seq.sv
// Bench for arith_cmd_seq: two instances (settle 1 and settle 4), each driving
// a behavioural model of the 4-bit arithmetic/compare unit.
// Responses are predicted from the command fields alone.
module tb_arith_cmd_seq;
    import arith_pkg::*;

    localparam int S1 = 1;
    localparam int S4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance with SETTLE_CYCLES = 1 ----------------
    logic       rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
    logic [1:0] cmd_op, alu_ctrl;
    logic [2:0] alu_flag, rsp_flag;
    logic [7:0] rsp_count;

    // ---------------- instance with SETTLE_CYCLES = 4 ----------------
    logic       rst_4, cmd_valid_4, cmd_ready_4, rsp_valid_4, rsp_ready_4, rsp_err_4, busy_4;
    logic [3:0] cmd_a_4, cmd_b_4, alu_a_4, alu_b_4, alu_result_4, rsp_result_4;
    logic [1:0] cmd_op_4, alu_ctrl_4;
    logic [2:0] alu_flag_4, rsp_flag_4;
    logic [7:0] rsp_count_4;

    arith_cmd_seq #(.SETTLE_CYCLES(S1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy), .rsp_count(rsp_count)
    );

    arith_cmd_seq #(.SETTLE_CYCLES(S4)) dut_4 (
        .clk(clk), .rst(rst_4), .cmd_valid(cmd_valid_4), .cmd_ready(cmd_ready_4),
        .cmd_a(cmd_a_4), .cmd_b(cmd_b_4), .cmd_op(cmd_op_4),
        .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_ctrl(alu_ctrl_4),
        .alu_result(alu_result_4), .alu_flag(alu_flag_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_result(rsp_result_4),
        .rsp_flag(rsp_flag_4), .rsp_err(rsp_err_4), .busy(busy_4), .rsp_count(rsp_count_4)
    );

    // Behavioural stand-in for the team's 4-bit arithmetic/compare unit.
    function automatic logic [6:0] alu_unit(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [2:0] f;
        logic [3:0] r;
        f = {a > b, a == b, a < b};
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_CMP:  r = {1'b0, f};
            default: r = 4'd0;
        endcase
        return {r, f};
    endfunction

    assign {alu_result, alu_flag}     = alu_unit(alu_ctrl, alu_a, alu_b);
    assign {alu_result_4, alu_flag_4} = alu_unit(alu_ctrl_4, alu_a_4, alu_b_4);

    // Reference: expected {rsp_err, rsp_result, rsp_flag} from the command.
    function automatic logic [7:0] ref_rsp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, res;
        logic [2:0] fl;
        ia = int'(a);
        ib = int'(b);
        if (ia > ib)       fl = 3'b100;
        else if (ia == ib) fl = 3'b010;
        else               fl = 3'b001;
        case (op)
            2'd0:    res = (ia + ib) % 16;
            2'd1:    res = (ia - ib + 16) % 16;
            2'd2:    res = int'(fl);
            default: res = 0;
        endcase
        return {op == 2'd3, 4'(res), fl};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_cnt = 8'd0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the settle-1 instance. Junk commands are offered
    // while busy and rsp_ready toggles outside RESP; both must be ignored.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input int hold, input logic [7:0] e);
        int lat;
        lat = 0;
        while (!cmd_ready && lat < 50) begin
            step();
            lat++;
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        step();
        chk("alu_operands", 32'({alu_ctrl, alu_a, alu_b}), 32'({op, a, b}));
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            chk("settle_busy_ready", 32'({busy, cmd_ready}), 32'b10);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_op    = 2'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(S1 + 1));
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("rsp_hold", 32'({rsp_valid, rsp_err, rsp_result, rsp_flag}), 32'({1'b1, e}));
            chk("hold_ready_alu", 32'({cmd_ready, alu_ctrl, alu_a, alu_b}), 32'({1'b0, op, a, b}));
            cmd_a  = 4'($urandom);
            cmd_b  = 4'($urandom);
            cmd_op = 2'($urandom);
            step();
        end
        chk("rsp_data", 32'({rsp_valid, rsp_err, rsp_result, rsp_flag}), 32'({1'b1, e}));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        chk("post_hs_valid_busy", 32'({rsp_valid, busy}), 32'd0);
        chk("rsp_count", 32'(rsp_count), 32'(exp_cnt));
        chk("post_hs_ready", 32'(cmd_ready), 32'd1);
        chk("rsp_retained", 32'({rsp_result, rsp_flag}), 32'(e[6:0]));
        chk("alu_retained", 32'({alu_ctrl, alu_a, alu_b}), 32'({op, a, b}));
    endtask

    // One full transaction on the settle-4 instance.
    task automatic do_cmd4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] e, input logic [7:0] ecnt);
        int lat;
        chk("s4_cmd_ready", 32'(cmd_ready_4), 32'd1);
        cmd_valid_4 = 1'b1;
        cmd_a_4     = a;
        cmd_b_4     = b;
        cmd_op_4    = op;
        step();
        cmd_valid_4 = 1'b0;
        lat = 1;
        while (!rsp_valid_4 && lat < 20) begin
            step();
            lat++;
        end
        chk("s4_latency", 32'(lat), 32'(S4 + 1));
        chk("s4_rsp_data", 32'({rsp_err_4, rsp_result_4, rsp_flag_4}), 32'(e));
        rsp_ready_4 = 1'b1;
        step();
        rsp_ready_4 = 1'b0;
        chk("s4_rsp_count", 32'(rsp_count_4), 32'(ecnt));
        chk("s4_post_hs", 32'({rsp_valid_4, cmd_ready_4}), 32'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        logic [3:0] a, b;

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 2'd0; rsp_ready = 1'b0;
        rst_4 = 1'b1; cmd_valid_4 = 1'b0; cmd_a_4 = 4'd0; cmd_b_4 = 4'd0; cmd_op_4 = 2'd0; rsp_ready_4 = 1'b0;

        // Reset state; rsp_ready and cmd_valid high during reset do nothing.
        step();
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        repeat (2) step();
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_alu", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
        chk("reset_rsp", 32'({rsp_valid, rsp_result, rsp_flag, rsp_err, busy}), 32'd0);
        chk("reset_count", 32'(rsp_count), 32'd0);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Directed cases with literal expectations: {err, result, flag}.
        do_cmd(OP_ADD,  4'd9, 4'd8, 5, 8'b0_0001_100);
        do_cmd(OP_SUB,  4'd3, 4'd5, 0, 8'b0_1110_001);
        do_cmd(OP_CMP,  4'd7, 4'd7, 1, 8'b0_0010_010);
        do_cmd(OP_RSVD, 4'd2, 4'd1, 2, 8'b1_0000_100);

        // Randomized traffic, long enough to wrap rsp_count past 255.
        for (int i = 0; i < 260; i++) begin
            op = 2'($urandom);
            a  = 4'($urandom);
            b  = 4'($urandom);
            do_cmd(op, a, b, int'($urandom_range(0, 3)), ref_rsp(op, a, b));
        end

        // Settle-4 instance: reset release, one command, abort via reset in
        // the second SETTLE cycle, then a clean command.
        chk("s4_reset_ready", 32'(cmd_ready_4), 32'd0);
        rst_4 = 1'b0;
        #1;
        do_cmd4(OP_ADD, 4'd5, 4'd6, 8'b0_1011_001, 8'd1);
        cmd_valid_4 = 1'b1; cmd_op_4 = OP_CMP; cmd_a_4 = 4'd9; cmd_b_4 = 4'd3;
        step();
        cmd_valid_4 = 1'b0;
        chk("s4_settle1_busy", 32'(busy_4), 32'd1);
        step();
        rst_4 = 1'b1;
        step();
        rst_4 = 1'b0;
        chk("s4_abort_alu", 32'({alu_a_4, alu_b_4, alu_ctrl_4}), 32'd0);
        chk("s4_abort_rsp", 32'({rsp_valid_4, rsp_result_4, rsp_flag_4, rsp_err_4, busy_4}), 32'd0);
        chk("s4_abort_count", 32'(rsp_count_4), 32'd0);
        #1;
        chk("s4_abort_ready", 32'(cmd_ready_4), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("s4_no_rsp", 32'(rsp_valid_4), 32'd0);
            step();
        end
        do_cmd4(OP_SUB, 4'd1, 4'd2, 8'b0_1111_001, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
